// File: rtl/draw_sched_pkg.sv
// Shared definitions for the draw scheduler: state encoding, client indices,
// erase colour and default bus widths.
package draw_sched_pkg;

    localparam int COORD_W_DEF  = 10;
    localparam int COLOUR_W_DEF = 3;

    // State encoding
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ERASE_GO   = 3'd1;
    localparam logic [2:0] ST_ERASE_WAIT = 3'd2;
    localparam logic [2:0] ST_LOGIC      = 3'd3;
    localparam logic [2:0] ST_LOGIC_WAIT = 3'd4;
    localparam logic [2:0] ST_DRAW_GO    = 3'd5;
    localparam logic [2:0] ST_DRAW_WAIT  = 3'd6;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        ERASE_GO   = ST_ERASE_GO,
        ERASE_WAIT = ST_ERASE_WAIT,
        LOGIC      = ST_LOGIC,
        LOGIC_WAIT = ST_LOGIC_WAIT,
        DRAW_GO    = ST_DRAW_GO,
        DRAW_WAIT  = ST_DRAW_WAIT
    } sched_state_t;

    // Engines are served in this order in both passes
    typedef logic [1:0] client_t;
    localparam client_t CL_BALL  = 2'd0;
    localparam client_t CL_BRICK = 2'd1;
    localparam client_t CL_PLAT  = 2'd2;

    localparam logic [2:0] BLACK = 3'b000;

    // One-hot go vector bit for a client; bit order matches the client index
    function automatic logic [2:0] client_onehot(input client_t c);
        case (c)
            CL_BALL:  return 3'b001;
            CL_BRICK: return 3'b010;
            CL_PLAT:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/draw_cycle_counter.sv
// Clear/enable cycle counter with a terminal-count compare. Used for the
// fixed game-logic wait and for the optional engine-done timeout.
module draw_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         hit
);

    logic [W-1:0] count;

    // Count enabled cycles; clear wins over enable
    always_ff @(posedge clk) begin
        if (!resetn || clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    // Terminal count only reported while counting
    assign hit = en && (count == last);

endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer and pixel-port arbiter for the ball, brick and platform
// draw engines: erase pass (black), game-logic step, draw pass (colour).
// Optional build macro SCHED_TIMEOUT_EN adds an engine-done timeout and the
// timeout_err output.
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int COORD_W      = COORD_W_DEF,
    parameter int COLOUR_W     = COLOUR_W_DEF,
    parameter int LOGIC_CYCLES = 12,
    parameter int TIMEOUT      = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                frame_tick,
    input  logic                ball_done,
    input  logic                brick_done,
    input  logic                plat_done,
    input  logic [COORD_W-1:0]  ball_x,
    input  logic [COORD_W-1:0]  brick_x,
    input  logic [COORD_W-1:0]  plat_x,
    input  logic [COORD_W-1:0]  ball_y,
    input  logic [COORD_W-1:0]  brick_y,
    input  logic [COORD_W-1:0]  plat_y,
    input  logic [COLOUR_W-1:0] ball_colour,
    input  logic [COLOUR_W-1:0] brick_colour,
    input  logic [COLOUR_W-1:0] plat_colour,
    input  logic                ball_we,
    input  logic                brick_we,
    input  logic                plat_we,
    output logic                ball_go,
    output logic                brick_go,
    output logic                plat_go,
    output logic                logic_go,
    output logic [COORD_W-1:0]  vga_x,
    output logic [COORD_W-1:0]  vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_we,
    output logic                drawing,
    output logic                frame_done,
`ifdef SCHED_TIMEOUT_EN
    output logic                timeout_err,
`endif
    output logic                frame_overrun
);

    if (LOGIC_CYCLES < 1 || TIMEOUT < 2) begin : g_bad_params
        $error("draw_scheduler: LOGIC_CYCLES must be >= 1 and TIMEOUT >= 2");
    end

    localparam int           LW         = $clog2(LOGIC_CYCLES + 1);
    localparam logic [LW-1:0] LOGIC_LAST = LW'(LOGIC_CYCLES - 1);

    sched_state_t state;
    client_t      idx;
    logic         pending;
    logic [2:0]   go_r;

    logic                sel_done;
    logic                sel_we;
    logic [COORD_W-1:0]  sel_x;
    logic [COORD_W-1:0]  sel_y;
    logic [COLOUR_W-1:0] sel_colour;

    logic pass_active;
    logic in_wait;
    logic in_draw;
    logic logic_hit;
    logic to_hit;

    assign pass_active = (state == ERASE_GO) || (state == ERASE_WAIT) ||
                         (state == DRAW_GO)  || (state == DRAW_WAIT);
    assign in_wait     = (state == ERASE_WAIT) || (state == DRAW_WAIT);
    assign in_draw     = (state == DRAW_GO) || (state == DRAW_WAIT);

    assign ball_go  = go_r[CL_BALL];
    assign brick_go = go_r[CL_BRICK];
    assign plat_go  = go_r[CL_PLAT];

    // Game-logic settle time: counts the LOGIC_WAIT cycles
    draw_cycle_counter #(.W(LW)) u_logic_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state != LOGIC_WAIT),
        .en     (state == LOGIC_WAIT),
        .last   (LOGIC_LAST),
        .hit    (logic_hit)
    );

`ifdef SCHED_TIMEOUT_EN
    // The go cycle counts toward the budget, so the wait expires after
    // TIMEOUT-1 cycles in *_WAIT and timeout_err lands TIMEOUT cycles after go.
    localparam int            TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);

    draw_cycle_counter #(.W(TW)) u_timeout_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (!in_wait),
        .en     (in_wait),
        .last   (TO_LAST),
        .hit    (to_hit)
    );
`else
    assign to_hit = 1'b0;
`endif

    // Select the current client's handshake and pixel signals
    always_comb begin
        sel_done   = 1'b0;
        sel_we     = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        case (idx)
            CL_BALL: begin
                sel_done = ball_done;  sel_we = ball_we;
                sel_x = ball_x;  sel_y = ball_y;  sel_colour = ball_colour;
            end
            CL_BRICK: begin
                sel_done = brick_done; sel_we = brick_we;
                sel_x = brick_x; sel_y = brick_y; sel_colour = brick_colour;
            end
            CL_PLAT: begin
                sel_done = plat_done;  sel_we = plat_we;
                sel_x = plat_x;  sel_y = plat_y;  sel_colour = plat_colour;
            end
            default: ;
        endcase
    end

    // Pixel port: pass-through of the selected engine, black while erasing
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_we     = 1'b0;
        if (pass_active) begin
            vga_x      = sel_x;
            vga_y      = sel_y;
            vga_we     = sel_we;
            vga_colour = in_draw ? sel_colour : COLOUR_W'(BLACK);
        end
    end

    // Frame sequencer with registered strobes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            idx           <= CL_BALL;
            pending       <= 1'b0;
            go_r          <= '0;
            logic_go      <= 1'b0;
            drawing       <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            timeout_err   <= 1'b0;
`endif
        end else begin
            go_r          <= '0;
            logic_go      <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            timeout_err   <= 1'b0;
`endif
            // A tick while busy is remembered once; further ticks collapse
            if (frame_tick && state != IDLE) begin
                pending       <= 1'b1;
                frame_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_tick || pending) begin
                        state   <= ERASE_GO;
                        idx     <= CL_BALL;
                        pending <= 1'b0;
                        go_r    <= client_onehot(CL_BALL);
                    end
                end
                ERASE_GO: state <= ERASE_WAIT;
                ERASE_WAIT: begin
                    if (sel_done || to_hit) begin
`ifdef SCHED_TIMEOUT_EN
                        timeout_err <= !sel_done;
`endif
                        if (idx == CL_PLAT) begin
                            idx      <= CL_BALL;
                            state    <= LOGIC;
                            logic_go <= 1'b1;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= ERASE_GO;
                            go_r  <= client_onehot(idx + 2'd1);
                        end
                    end
                end
                LOGIC: state <= LOGIC_WAIT;
                LOGIC_WAIT: begin
                    if (logic_hit) begin
                        state   <= DRAW_GO;
                        drawing <= 1'b1;
                        go_r    <= client_onehot(CL_BALL);
                    end
                end
                DRAW_GO: state <= DRAW_WAIT;
                DRAW_WAIT: begin
                    if (sel_done || to_hit) begin
`ifdef SCHED_TIMEOUT_EN
                        timeout_err <= !sel_done;
`endif
                        if (idx == CL_PLAT) begin
                            idx        <= CL_BALL;
                            state      <= IDLE;
                            drawing    <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= DRAW_GO;
                            go_r  <= client_onehot(idx + 2'd1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    idx     <= CL_BALL;
                    drawing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
Sequences and arbitrates the single VGA pixel write port among the three draw engines: ball, bricks and platform. On each frame tick it runs an erase pass (black) over all engines, then pulses game logic, then runs a draw pass (engine colours). It replaces fixed-delay draw sequencing with go/done handshakes per engine. It sits between the draw engines and the VGA adapter, and is paced by delay_counter.

Parameters:
COORD_W, 10, pixel coordinate width
COLOUR_W, 3, colour width
LOGIC_CYCLES, 12, cycles to wait after logic_go before the draw pass starts
TIMEOUT, 1024, max cycles to wait for an engine done (only with SCHED_TIMEOUT_EN)

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle frame pulse from delay_counter
ball_done / brick_done / plat_done  in  1 each  engine finished its current pass
ball_x / brick_x / plat_x  in  COORD_W each  engine pixel x
ball_y / brick_y / plat_y  in  COORD_W each  engine pixel y
ball_colour / brick_colour / plat_colour  in  COLOUR_W each  engine pixel colour
ball_we / brick_we / plat_we  in  1 each  engine pixel write strobe
ball_go / brick_go / plat_go  out  1 each  one-cycle start pulse to engine
logic_go  out  1  one-cycle game-logic step pulse (ball_logic, ball_pos, platform)
vga_x / vga_y  out  COORD_W each  muxed pixel coordinate
vga_colour  out  COLOUR_W  muxed colour, forced to 0 in erase pass
vga_we  out  1  muxed write strobe
drawing  out  1  1 during the draw pass (colour phase)
frame_done  out  1  one-cycle pulse when the draw pass completes
frame_overrun  out  1  one-cycle pulse when a frame_tick arrives while busy

Behaviour:
- Reset (synchronous, resetn=0 on a clk edge): state IDLE, client index 0, pending=0. All outputs are 0. A reset mid-pass abandons the pass immediately and issues no further go pulses.
- States: IDLE, ERASE_GO, ERASE_WAIT, LOGIC, LOGIC_WAIT, DRAW_GO, DRAW_WAIT. A 2-bit client index selects the engine in order: 0 ball, 1 bricks, 2 plat.
- IDLE -> ERASE_GO when frame_tick=1 or pending=1. Entering clears pending.
- ERASE_GO: asserts the selected engine's go for exactly one cycle, then moves to ERASE_WAIT.
- ERASE_WAIT: done is sampled only in this state. A done from a non-selected engine is ignored. On the selected done:
  - index<2: index++ and go to ERASE_GO.
  - index=2: index=0 and go to LOGIC.
- LOGIC: logic_go=1 for one cycle and the cycle counter is cleared. LOGIC_WAIT follows and lasts LOGIC_CYCLES cycles, then the FSM moves to DRAW_GO.
- DRAW_GO / DRAW_WAIT: same as the erase states, with drawing=1. After plat done: frame_done pulses, index=0, state returns to IDLE.
- Pixel mux: in *_GO and *_WAIT states, vga_x, vga_y and vga_we follow the selected engine combinationally (zero added latency).
  - vga_colour is 0 in the erase states and the engine colour in the draw states.
  - In all other states vga_we=0 and x, y and colour are 0.
- A go pulse and a done in the same cycle: the done is ignored. The engine must raise done in a later cycle.
- frame_tick while not IDLE: sets pending (sticky, 1 bit) and pulses frame_overrun. Multiple overruns collapse into one pending frame. A tick in the same cycle as frame_done is also latched as pending.
- Minimum frame latency from tick to frame_done: 3×(1+1) erase + 1 + LOGIC_CYCLES + 3×(1+1) draw, i.e. 13+LOGIC_CYCLES cycles with done returned immediately.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined: a counter runs in each *_WAIT state. If TIMEOUT cycles elapse without the selected done, the scheduler treats the engine as done, advances, and pulses output timeout_err (1 bit, reset 0) for one cycle.
- Undefined: no counter and no timeout_err port. The scheduler waits indefinitely for done.

Decomposition:
- Shared package draw_sched_pkg holds:
  - the state encoding localparams;
  - client indices CL_BALL=0, CL_BRICK=1, CL_PLAT=2;
  - BLACK=3'b000;
  - the COORD_W and COLOUR_W defaults.
- One sub-module, draw_cycle_counter: a synchronous clear/enable counter with a terminal-count compare. It serves both LOGIC_WAIT and the optional timeout.

Test Plan:
- Reset with all dones tied to respond 1 cycle after go; tick at cycle 5 -> go order ball, brick, plat (erase), logic_go, ball, brick, plat (draw); frame_done at cycle 5+13+12=30; drawing=1 only in draw states.
- Erase pass with brick_we=1, brick_colour=3'b101, brick_x=40 -> vga_colour=0, vga_x=40; draw pass -> vga_colour=3'b101.
- Hold brick_done=0 for 500 cycles -> no plat_go, vga_we follows brick_we only; release -> plat_go next cycle.
- Tick twice during an erase pass -> frame_overrun pulses twice; exactly one extra frame starts immediately after frame_done.
- resetn=0 during DRAW_WAIT with index=1 -> next cycle all outputs 0, state IDLE; no plat_go until the next tick.
- With SCHED_TIMEOUT_EN and TIMEOUT=16, plat never done -> timeout_err pulses 16 cycles after plat_go and the sequence continues to LOGIC.
